// File: rtl/modn_timer_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// modn_pkg
// Shared definitions for the mod-N timer controller:
//   state_e : controller FSM state encoding (also driven out on state_o)
//   MIN_N   : smallest legal modulus; cfg_n values below it are rejected
// -----------------------------------------------------------------------------
package modn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MIN_N = 2;

endpackage : modn_pkg

// File: rtl/modn_timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// modn_timer_ctrl_if
// Configuration handshake between a host (master) and the timer controller
// (slave).
//   cfg_valid    : master offers a configuration
//   cfg_ready    : slave can accept it (controller is IDLE)
//   cfg_n        : requested modulus
//   cfg_periodic : 1 = free-running, 0 = one-shot
//   cfg_reps     : one-shot runs cfg_reps+1 periods
//   cfg_err      : one-cycle pulse after an illegal cfg_n was rejected
// -----------------------------------------------------------------------------
interface modn_timer_ctrl_if
    import modn_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RPT_W = 4
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_n;
    logic             cfg_periodic;
    logic [RPT_W-1:0] cfg_reps;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_n,
        output cfg_periodic,
        output cfg_reps,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        input  cfg_periodic,
        input  cfg_reps,
        output cfg_ready,
        output cfg_err
    );

endinterface : modn_timer_ctrl_if

// File: rtl/modn_timer_ctrl_count_core.sv
// -----------------------------------------------------------------------------
// modn_count_core
// Mod-n up counter with clear and enable.
//   clk, reset : clock and synchronous active-high reset
//   en_i       : advance the count this cycle
//   clr_i      : force the count to zero (wins over en_i)
//   n_i        : modulus; the count runs 0..n_i-1
//   q_o        : current count
//   wrap_o     : en_i && q_o == n_i-1 (the count returns to 0 next cycle)
// -----------------------------------------------------------------------------
module modn_count_core
    import modn_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             at_top;

    assign at_top = (q_q == (n_i - ONE));

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = at_top ? '0 : (q_q + ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = en_i && at_top;

endmodule : modn_count_core

// File: rtl/modn_timer_ctrl.sv
// -----------------------------------------------------------------------------
// modn_timer_ctrl
// Run-time controller for a mod-N counter: takes modulus/mode configuration
// over a valid/ready handshake, runs one-shot (reps+1 periods) or periodic,
// supports pause and stop, and flags terminal count and completion.
//   clk, reset : clock and synchronous active-high reset
//   cfg        : configuration handshake (slave side)
//   start_i    : level, only looked at in IDLE
//   pause_i    : level, counter holds while high
//   stop_i     : level, abort to IDLE
//   q_o        : current count
//   tc_o       : high in each cycle the count wraps N-1 -> 0
//   busy_o     : state is RUN or PAUSE
//   done_o     : high for the single DONE cycle
//   state_o    : current FSM state
// -----------------------------------------------------------------------------
module modn_timer_ctrl
    import modn_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEFAULT_N = 12,
    parameter int RPT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    modn_timer_ctrl_if.slave cfg,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o,
    output state_e           state_o
);

    localparam logic [WIDTH-1:0] MIN_N_W = WIDTH'(MIN_N);
    localparam logic [WIDTH-1:0] DEF_N_W = WIDTH'(DEFAULT_N);
    localparam logic [RPT_W-1:0] ONE_R   = RPT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] n_q;
    logic             periodic_q;
    logic [RPT_W-1:0] reps_q;
    logic [RPT_W-1:0] rep_cnt_q;
    logic             cfg_err_q;

    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_wrap;
    logic             last_period;
    logic             busy;

    assign busy = (state_q == RUN) || (state_q == PAUSE);

    // Counting only happens in RUN with neither stop nor pause, which is
    // exactly when a wrap may raise tc. The count is held at zero outside
    // a run and cleared when a run is aborted.
    assign cnt_en  = (state_q == RUN) && !stop_i && !pause_i;
    assign cnt_clr = (state_q == IDLE) || (state_q == DONE) || (busy && stop_i);

    modn_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .en_i   (cnt_en),
        .clr_i  (cnt_clr),
        .n_i    (n_q),
        .q_o    (q_o),
        .wrap_o (cnt_wrap)
    );

    assign last_period = !periodic_q && (rep_cnt_q == reps_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= DEF_N_W;
            periodic_q <= 1'b0;
            reps_q     <= '0;
            rep_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Mode and repeat count are taken even when the modulus
                    // is rejected; only n keeps its old value.
                    if (cfg.cfg_valid) begin
                        if (cfg.cfg_n >= MIN_N_W) begin
                            n_q <= cfg.cfg_n;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                        periodic_q <= cfg.cfg_periodic;
                        reps_q     <= cfg.cfg_reps;
                    end
                    if (start_i) begin
                        state_q   <= RUN;
                        rep_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end else if (pause_i) begin
                        state_q <= PAUSE;
                    end else if (cnt_wrap) begin
                        if (last_period) begin
                            state_q <= DONE;
                        end else if (rep_cnt_q == reps_q) begin
                            // Periodic mode: recycle so rep_cnt stays <= reps.
                            rep_cnt_q <= '0;
                        end else begin
                            rep_cnt_q <= rep_cnt_q + ONE_R;
                        end
                    end
                end
                PAUSE: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end else if (!pause_i) begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign cfg.cfg_err   = cfg_err_q;
    assign tc_o          = cnt_wrap;
    assign busy_o        = busy;
    assign done_o        = (state_q == DONE);
    assign state_o       = state_q;

endmodule : modn_timer_ctrl

// File: tb/tb_modn_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modn_timer_ctrl
// Directed scenarios with literal expectations, followed by randomized
// stimulus; a behavioural model checks every output on every cycle.
// -----------------------------------------------------------------------------
module tb_modn_timer_ctrl;
    import modn_pkg::*;

    localparam int W  = 4;
    localparam int R  = 4;
    localparam int DN = 12;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         stop  = 1'b0;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
    state_e       st;

    int checks = 0;
    int errors = 0;

    modn_timer_ctrl_if #(.WIDTH(W), .RPT_W(R)) cfg_if ();

    modn_timer_ctrl #(
        .WIDTH     (W),
        .DEFAULT_N (DN),
        .RPT_W     (R)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg     (cfg_if),
        .start_i (start),
        .pause_i (pause),
        .stop_i  (stop),
        .q_o     (q),
        .tc_o    (tc),
        .busy_o  (busy),
        .done_o  (done),
        .state_o (st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase numbers follow the state_o encoding: 0 idle, 1 run, 2 pause, 3 done.
    // A one-shot run ends once reps+1 full periods have been counted.
    int m_valid = 0;
    int m_st, m_q, m_n, m_per, m_reps, m_periods, m_err;

    always @(negedge clk) begin
        int nerr;
        int exp_tc;
        #2;
        if (m_valid != 0) begin
            exp_tc = (m_st == 1 && !stop && !pause && m_q == m_n - 1) ? 1 : 0;
            chk("model_q",     int'(q),                m_q);
            chk("model_tc",    int'(tc),               exp_tc);
            chk("model_busy",  int'(busy),             (m_st == 1 || m_st == 2) ? 1 : 0);
            chk("model_done",  int'(done),             (m_st == 3) ? 1 : 0);
            chk("model_state", int'(st),               m_st);
            chk("model_ready", int'(cfg_if.cfg_ready), (m_st == 0) ? 1 : 0);
            chk("model_err",   int'(cfg_if.cfg_err),   m_err);
        end
        if (reset) begin
            m_valid = 1; m_st = 0; m_q = 0; m_n = DN; m_per = 0;
            m_reps = 0; m_periods = 0; m_err = 0;
        end else if (m_valid != 0) begin
            nerr = 0;
            case (m_st)
                0: begin
                    if (cfg_if.cfg_valid) begin
                        if (int'(cfg_if.cfg_n) >= 2) m_n = int'(cfg_if.cfg_n);
                        else nerr = 1;
                        m_per  = int'(cfg_if.cfg_periodic);
                        m_reps = int'(cfg_if.cfg_reps);
                    end
                    if (start) begin m_st = 1; m_q = 0; m_periods = 0; end
                end
                1: begin
                    if (stop) begin m_st = 0; m_q = 0; end
                    else if (pause) m_st = 2;
                    else if (m_q == m_n - 1) begin
                        m_q = 0;
                        m_periods++;
                        if (m_per == 0 && m_periods == m_reps + 1) m_st = 3;
                    end else m_q++;
                end
                2: begin
                    if (stop) begin m_st = 0; m_q = 0; end
                    else if (!pause) m_st = 1;
                end
                default: begin m_st = 0; m_q = 0; end
            endcase
            m_err = nerr;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change at negedge+1, the model checks at +2, literal checks at +3.
    task automatic clk1();
        @(negedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic idle_inputs();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_cfg(input int n, input int per, input int reps);
        cfg_if.cfg_valid    = 1'b1;
        cfg_if.cfg_n        = W'(n);
        cfg_if.cfg_periodic = per[0];
        cfg_if.cfg_reps     = R'(reps);
    endtask

    // Called right after the IDLE cycle that had start=1.
    task automatic run_check(input string tag, input int n, input int periods);
        for (int k = 0; k < n * periods; k++) begin
            clk1(); idle_inputs(); look();
            chk({tag, "_q"},    int'(q),    k % n);
            chk({tag, "_tc"},   int'(tc),   (k % n == n - 1) ? 1 : 0);
            chk({tag, "_busy"}, int'(busy), 1);
        end
        clk1(); look();
        chk({tag, "_done"},   int'(done), 1);
        chk({tag, "_done_q"}, int'(q),    0);
        clk1(); look();
        chk({tag, "_idle"},   int'(st),   0);
        chk({tag, "_nbusy"},  int'(busy), 0);
    endtask

    initial begin
        idle_inputs();
        cfg_if.cfg_n = '0; cfg_if.cfg_periodic = 1'b0; cfg_if.cfg_reps = '0;
        reset = 1'b1;
        clk1(); clk1();
        reset = 1'b0;
        look();
        chk("rst_q",     int'(q),                0);
        chk("rst_state", int'(st),               0);
        chk("rst_ready", int'(cfg_if.cfg_ready), 1);
        chk("rst_busy",  int'(busy),             0);
        chk("rst_done",  int'(done),             0);
        chk("rst_tc",    int'(tc),               0);
        chk("rst_err",   int'(cfg_if.cfg_err),   0);

        // Defaults: N=12 one-shot, one period.
        clk1(); start = 1'b1;
        run_check("t1", 12, 1);

        // N=5, reps=2, config and start in the same cycle.
        clk1(); set_cfg(5, 0, 2); start = 1'b1;
        run_check("t2", 5, 3);

        // N=3 periodic, stop in a q=2 cycle.
        clk1(); set_cfg(3, 1, 0); start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clk1(); idle_inputs(); look();
            chk("t3_q", int'(q), k % 3);
        end
        clk1(); stop = 1'b1; look();
        chk("t3_stop_q",  int'(q),  2);
        chk("t3_stop_tc", int'(tc), 0);
        clk1(); stop = 1'b0; look();
        chk("t3_idle", int'(st), 0);
        chk("t3_q0",   int'(q),  0);

        // N=8, pause for three cycles starting at q=4.
        clk1(); set_cfg(8, 0, 0); start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clk1(); idle_inputs(); look();
            chk("t4_q", int'(q), k);
        end
        for (int k = 0; k < 3; k++) begin
            clk1(); pause = 1'b1; look();
            chk("t4_hold_q",  int'(q),  4);
            chk("t4_hold_tc", int'(tc), 0);
        end
        clk1(); pause = 1'b0; look();
        chk("t4_unpause_q",  int'(q),  4);
        chk("t4_unpause_st", int'(st), 2);
        clk1(); look();
        chk("t4_resume_q",  int'(q),  4);
        chk("t4_resume_st", int'(st), 1);
        for (int k = 5; k < 8; k++) begin
            clk1(); look();
            chk("t4_q2",  int'(q),  k);
            chk("t4_tc2", int'(tc), (k == 7) ? 1 : 0);
        end
        clk1(); look();
        chk("t4_done", int'(done), 1);
        clk1();

        // Illegal modulus in IDLE, then a config offered during RUN.
        set_cfg(1, 0, 0); look();
        chk("t5_ready", int'(cfg_if.cfg_ready), 1);
        clk1(); cfg_if.cfg_valid = 1'b0; look();
        chk("t5_err", int'(cfg_if.cfg_err), 1);
        clk1(); look();
        chk("t5_err_clr", int'(cfg_if.cfg_err), 0);
        clk1(); start = 1'b1;
        clk1(); start = 1'b0; set_cfg(6, 1, 0); look();
        chk("t5_run_ready", int'(cfg_if.cfg_ready), 0);
        chk("t5_run_q",     int'(q),                0);
        for (int k = 1; k < 8; k++) begin
            clk1(); look();
            chk("t5_q",  int'(q),  k);
            chk("t5_tc", int'(tc), (k == 7) ? 1 : 0);
        end
        clk1(); cfg_if.cfg_valid = 1'b0; look();
        chk("t5_done", int'(done), 1);
        clk1(); look();
        chk("t5_idle", int'(st), 0);

        // N=10, reset at q=7; afterwards the default N=12 is back.
        clk1(); set_cfg(10, 0, 0); start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            clk1(); idle_inputs(); look();
            chk("t6_q", int'(q), k);
        end
        clk1(); reset = 1'b1; look();
        chk("t6_pre_q", int'(q), 7);
        clk1(); reset = 1'b0; look();
        chk("t6_state", int'(st),   0);
        chk("t6_q0",    int'(q),    0);
        chk("t6_tc",    int'(tc),   0);
        chk("t6_done",  int'(done), 0);
        chk("t6_busy",  int'(busy), 0);
        clk1(); start = 1'b1;
        run_check("t6", 12, 1);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            clk1();
            reset               = ($urandom_range(0, 199) == 0);
            cfg_if.cfg_valid    = ($urandom_range(0, 4) == 0);
            cfg_if.cfg_n        = W'($urandom_range(0, 15));
            cfg_if.cfg_periodic = $urandom_range(0, 1) == 1;
            cfg_if.cfg_reps     = R'($urandom_range(0, 3));
            start               = ($urandom_range(0, 4) == 0);
            pause               = ($urandom_range(0, 9) == 0);
            stop                = ($urandom_range(0, 29) == 0);
        end
        clk1(); idle_inputs(); reset = 1'b0;
        clk1(); look();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_modn_timer_ctrl

// File: doc/modn_timer_ctrl.md
Name: modn_timer_ctrl

Overview:
Run-time controller that sequences a programmable mod-N counter core.
- Accepts modulus/mode configuration through a valid/ready handshake.
- Runs the counter one-shot (a fixed number of periods) or periodically, with pause and stop.
- Emits terminal-count and done pulses for downstream timing and event logic.

Parameters:
WIDTH, 4, counter width in bits; the maximum usable modulus is 2^WIDTH-1.
DEFAULT_N, 12, modulus loaded at reset; legal range is 2..2^WIDTH-1.
RPT_W, 4, width of the repeat-count field.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration offer
cfg_ready  output  1  config accepted; equals (state==IDLE)
cfg_n  input  WIDTH  requested modulus
cfg_periodic  input  1  1 = free-running, 0 = one-shot
cfg_reps  input  RPT_W  one-shot runs cfg_reps+1 periods
cfg_err  output  1  one-cycle pulse when an illegal cfg_n is rejected
start  input  1  level, sampled only in IDLE
pause  input  1  level; counter holds while high
stop  input  1  level; abort to IDLE
q  output  WIDTH  current count
tc  output  1  high in each cycle the counter wraps N-1 -> 0
busy  output  1  state is RUN or PAUSE
done  output  1  high for the single DONE cycle
state  output  2  current FSM state (package enum)

Behaviour:
- All flops use synchronous reset; reset has priority over everything, including mid-run.
- Reset values: n_reg=DEFAULT_N, periodic_reg=0, reps_reg=0, rep_cnt=0, q=0, state=IDLE, cfg_ready=1. tc, cfg_err, done and busy are 0.
- Config capture:
  - Captured on an edge where cfg_valid && cfg_ready.
  - If cfg_n<2: n_reg is unchanged, cfg_err=1 for the next cycle, and periodic/reps are still captured.
  - cfg_valid outside IDLE is not captured.
- IDLE: q=0.
  - start=1 -> RUN next cycle, with q=0 and rep_cnt=0.
  - If cfg_valid and start arrive in the same cycle, the new config applies to the run.
- RUN priority: stop > pause > count.
  - stop: next state IDLE, q->0.
  - pause: next state PAUSE, q holds.
  - Otherwise q increments each cycle.
- Wrap: at q==n_reg-1, q->0 and tc=1.
  - tc = (state==RUN) && (q==n_reg-1) && !stop && !pause, so a stop or pause in the wrap cycle suppresses tc.
  - On wrap, one-shot with rep_cnt==reps_reg -> DONE; otherwise rep_cnt increments (periodic mode never enters DONE).
- PAUSE: q holds.
  - stop -> IDLE with q->0.
  - pause=0 -> RUN; counting resumes on the next cycle.
- DONE: lasts exactly one cycle with done=1 and q=0, then -> IDLE. start is ignored in DONE, RUN and PAUSE.
- Comparisons are WIDTH-bit unsigned. rep_cnt is RPT_W bits and never exceeds reps_reg.

Decomposition:
- Package modn_pkg holds:
  - typedef enum logic[1:0] state_e {IDLE=0, RUN=1, PAUSE=2, DONE=3}
  - helper constant MIN_N=2
- Sub-module modn_count_core:
  - Ports: clk, reset, en, clr, n[WIDTH], q, wrap.
  - Sync-reset mod-n counter. clr has priority over en. wrap = en && q==n-1.
- The controller instantiates one modn_count_core and owns the FSM, config registers and rep_cnt.

Test Plan:
- Reset, then start with defaults (N=12, one-shot, reps=0) -> q=0..11 over 12 RUN cycles; tc only at q=11; done in the 13th cycle after leaving IDLE; then IDLE.
- Config N=5, periodic=0, reps=2, then start -> three tc pulses 5 cycles apart; done after 15 RUN cycles; busy=1 throughout the run.
- Config N=3, periodic=1, start; assert stop in a cycle where q=2 -> no tc that cycle; next cycle state=IDLE, q=0.
- N=8 running; pause=1 for 3 cycles starting at q=4 -> q stays 4 for 4 cycles; resumes 5,6,7 with tc at 7; no tc during pause.
- In IDLE, cfg_valid with cfg_n=1 -> cfg_err pulses, n_reg unchanged. In RUN, cfg_valid with cfg_n=6 -> cfg_ready=0 and no capture.
- N=10 running; reset asserted at q=7 -> next cycle state=IDLE, q=0, n_reg=12, tc=0, done=0.
